// File: rtl/conv_ctrl_p.sv
// Convolution address/control sequencer: walks every kernel tap of every output pixel
// and channel, emitting RAM read addresses and MAC/write strobes aligned to the MAC pipe.
module conv_ctrl_p #(
    parameter int K        = 5,
    parameter int IN_W     = 32,
    parameter int IN_H     = 32,
    parameter int STRIDE   = 1,
    parameter int IN_CH    = 1,
    parameter int OUT_CH   = 6,
    parameter int FA_W     = 13,
    parameter int WA_W     = 10,
    parameter int OA_W     = 13,
    parameter int ADDR_LAT = 2,
    parameter int CLR_LAT  = 5,
    parameter int WR_LAT   = 9,
    localparam int BW      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic [FA_W-1:0] f_raddr,
    output logic [WA_W-1:0] w_raddr,
    output logic [BW-1:0]   b_raddr,
    output logic            mac_en,
    output logic            mac_clr,
    output logic [OA_W-1:0] o_waddr,
    output logic            o_wr_en
);

    localparam int OUT_W = (IN_W - K) / STRIDE + 1;
    localparam int OUT_H = (IN_H - K) / STRIDE + 1;
    // All three latencies must be >= 2: stage 1 holds partial products, the
    // consumer stage finishes the sum as it loads the output register.
    localparam int PD0   = (ADDR_LAT > CLR_LAT) ? ADDR_LAT : CLR_LAT;
    localparam int PD    = ((PD0 > WR_LAT) ? PD0 : WR_LAT) - 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [31:0] f0;     // ic*IN_W*IN_H + ox*STRIDE + kx
        logic [31:0] f1;     // input row: oy*STRIDE + ky
        logic [31:0] w0;     // (oc*IN_CH + ic)*K*K
        logic [31:0] w1;     // ky*K + kx
        logic [31:0] o0;     // oc*OUT_H*OUT_W
        logic [31:0] o1;     // oy*OUT_W + ox
        logic [31:0] b;
        logic        vld;
        logic        first;  // first tap of an output pixel
        logic        last;   // last tap of an output pixel
    } tap_t;

    state_t      state, state_n;
    logic [31:0] kx, ky, ic, ox, oy, oc;
    logic [31:0] flush_cnt;
    logic [5:0]  wrap;
    logic        tap_vld;
    tap_t        tap_in;
    tap_t        tp [1:PD];

    assign tap_vld = (state == RUN) && !stall;

    always_comb begin
        wrap    = '0;
        wrap[0] = (kx == 32'(K - 1));
        wrap[1] = wrap[0] && (ky == 32'(K - 1));
        wrap[2] = wrap[1] && (ic == 32'(IN_CH - 1));
        wrap[3] = wrap[2] && (ox == 32'(OUT_W - 1));
        wrap[4] = wrap[3] && (oy == 32'(OUT_H - 1));
        wrap[5] = wrap[4] && (oc == 32'(OUT_CH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (tap_vld && wrap[5]) state_n = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (flush_cnt == 32'(WR_LAT - 1)) state_n = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FLUSH lasts exactly WR_LAT cycles so the final write lands just before DONE.
    always_ff @(posedge clk) begin
        if (rst || state != FLUSH) flush_cnt <= '0;
        else                       flush_cnt <= flush_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            kx <= '0;
            ky <= '0;
            ic <= '0;
            ox <= '0;
            oy <= '0;
            oc <= '0;
        end else if (tap_vld) begin
            kx <= wrap[0] ? '0 : kx + 32'd1;
            if (wrap[0]) ky <= wrap[1] ? '0 : ky + 32'd1;
            if (wrap[1]) ic <= wrap[2] ? '0 : ic + 32'd1;
            if (wrap[2]) ox <= wrap[3] ? '0 : ox + 32'd1;
            if (wrap[3]) oy <= wrap[4] ? '0 : oy + 32'd1;
            if (wrap[4]) oc <= wrap[5] ? '0 : oc + 32'd1;
        end
    end

    always_comb begin
        tap_in       = '0;
        tap_in.f0    = ic * 32'(IN_W * IN_H) + ox * 32'(STRIDE) + kx;
        tap_in.f1    = oy * 32'(STRIDE) + ky;
        tap_in.w0    = (oc * 32'(IN_CH) + ic) * 32'(K * K);
        tap_in.w1    = ky * 32'(K) + kx;
        tap_in.o0    = oc * 32'(OUT_H * OUT_W);
        tap_in.o1    = oy * 32'(OUT_W) + ox;
        tap_in.b     = oc;
        tap_in.vld   = tap_vld;
        tap_in.first = (kx == '0) && (ky == '0) && (ic == '0);
        tap_in.last  = wrap[2];
    end

    // Stalled cycles push a bubble (vld=0) so downstream timing stays fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= PD; i++) tp[i] <= '0;
        end else begin
            tp[1] <= tap_in;
            for (int i = 2; i <= PD; i++) tp[i] <= tp[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_raddr <= '0;
            w_raddr <= '0;
            b_raddr <= '0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            o_wr_en <= 1'b0;
            o_waddr <= '0;
        end else begin
            if (tp[ADDR_LAT-1].vld) begin
                f_raddr <= FA_W'(tp[ADDR_LAT-1].f0 + tp[ADDR_LAT-1].f1 * 32'(IN_W));
                w_raddr <= WA_W'(tp[ADDR_LAT-1].w0 + tp[ADDR_LAT-1].w1);
                b_raddr <= BW'(tp[ADDR_LAT-1].b);
            end
            mac_en  <= tp[CLR_LAT-1].vld;
            mac_clr <= tp[CLR_LAT-1].vld & tp[CLR_LAT-1].first;
            o_wr_en <= tp[WR_LAT-1].vld & tp[WR_LAT-1].last;
            if (tp[WR_LAT-1].vld && tp[WR_LAT-1].last)
                o_waddr <= OA_W'(tp[WR_LAT-1].o0 + tp[WR_LAT-1].o1);
        end
    end

endmodule

// File: tb/tb_conv_ctrl_p.sv
// Directed bench for conv_ctrl_p: three configurations, observed tap/write streams
// compared against a loop-nest reference plus hand-computed spot values and latencies.
module tb_conv_ctrl_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, start_v, stall_v;

    logic        da_busy, da_done, da_en, da_clr, da_wr;
    logic [12:0] da_f, da_o;
    logic [9:0]  da_w;
    logic [0:0]  da_b;
    logic        db_busy, db_done, db_en, db_clr, db_wr;
    logic [12:0] db_f, db_o;
    logic [9:0]  db_w;
    logic [0:0]  db_b;
    logic        dc_busy, dc_done, dc_en, dc_clr, dc_wr;
    logic [12:0] dc_f, dc_o;
    logic [9:0]  dc_w;
    logic [0:0]  dc_b;

    conv_ctrl_p #(.OUT_CH(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stall(stall_v[0]),
        .busy(da_busy), .done(da_done), .f_raddr(da_f), .w_raddr(da_w), .b_raddr(da_b),
        .mac_en(da_en), .mac_clr(da_clr), .o_waddr(da_o), .o_wr_en(da_wr));

    conv_ctrl_p #(.K(3), .IN_W(6), .IN_H(6), .IN_CH(2), .OUT_CH(2)) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stall(stall_v[1]),
        .busy(db_busy), .done(db_done), .f_raddr(db_f), .w_raddr(db_w), .b_raddr(db_b),
        .mac_en(db_en), .mac_clr(db_clr), .o_waddr(db_o), .o_wr_en(db_wr));

    conv_ctrl_p #(.K(2), .IN_W(8), .IN_H(8), .STRIDE(2), .OUT_CH(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .stall(stall_v[2]),
        .busy(dc_busy), .done(dc_done), .f_raddr(dc_f), .w_raddr(dc_w), .b_raddr(dc_b),
        .mac_en(dc_en), .mac_clr(dc_clr), .o_waddr(dc_o), .o_wr_en(dc_wr));

    int   sel;
    logic m_busy, m_done, m_en, m_clr, m_wr;
    int   m_f, m_w, m_b, m_o;

    always_comb begin
        m_busy = db_busy; m_done = db_done; m_en = db_en; m_clr = db_clr; m_wr = db_wr;
        m_f = int'(db_f); m_w = int'(db_w); m_b = int'(db_b); m_o = int'(db_o);
        if (sel == 0) begin
            m_busy = da_busy; m_done = da_done; m_en = da_en; m_clr = da_clr; m_wr = da_wr;
            m_f = int'(da_f); m_w = int'(da_w); m_b = int'(da_b); m_o = int'(da_o);
        end else if (sel == 2) begin
            m_busy = dc_busy; m_done = dc_done; m_en = dc_en; m_clr = dc_clr; m_wr = dc_wr;
            m_f = int'(dc_f); m_w = int'(dc_w); m_b = int'(dc_b); m_o = int'(dc_o);
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Monitor: addresses appear 2 cycles after issue, mac_en 5 cycles after issue,
    // so each mac_en tap is paired with the addresses seen 3 cycles earlier.
    int cyc = 0;
    int hf [8], hw [8], hb [8];
    int q_f[$], q_w[$], q_b[$], q_clr[$], q_o[$];
    int n_done, c_busy1, c_mac1, c_wr1, c_wrl, c_done, c_fall;

    task automatic mon_clear();
        q_f.delete(); q_w.delete(); q_b.delete(); q_clr.delete(); q_o.delete();
        n_done = 0; c_busy1 = -1; c_mac1 = -1; c_wr1 = -1; c_wrl = -1; c_done = -1; c_fall = -1;
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        hf[cyc % 8] = m_f; hw[cyc % 8] = m_w; hb[cyc % 8] = m_b;
        if (m_busy && c_busy1 < 0) c_busy1 = cyc;
        if (m_en) begin
            q_f.push_back(hf[(cyc - 3) % 8]);
            q_w.push_back(hw[(cyc - 3) % 8]);
            q_b.push_back(hb[(cyc - 3) % 8]);
            q_clr.push_back(int'(m_clr));
            if (c_mac1 < 0) c_mac1 = cyc;
        end
        if (m_wr) begin
            q_o.push_back(m_o);
            if (c_wr1 < 0) c_wr1 = cyc;
            c_wrl = cyc;
        end
        if (m_done) begin
            n_done++;
            c_done = cyc;
        end
        if (!m_busy && c_done >= 0 && c_fall < 0 && cyc > c_done) c_fall = cyc;
    end

    int e_f[$], e_w[$], e_b[$], e_clr[$], e_o[$];

    task automatic build_exp(input int k, input int w, input int h, input int s,
                             input int ich, input int och);
        int ow, oh;
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        e_f.delete(); e_w.delete(); e_b.delete(); e_clr.delete(); e_o.delete();
        for (int oc = 0; oc < och; oc++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++) begin
                    for (int ic = 0; ic < ich; ic++)
                        for (int ky = 0; ky < k; ky++)
                            for (int kx = 0; kx < k; kx++) begin
                                e_f.push_back(ic * w * h + (oy * s + ky) * w + ox * s + kx);
                                e_w.push_back(((oc * ich + ic) * k + ky) * k + kx);
                                e_b.push_back(oc);
                                e_clr.push_back((kx == 0 && ky == 0 && ic == 0) ? 1 : 0);
                            end
                    e_o.push_back(oc * oh * ow + oy * ow + ox);
                end
    endtask

    task automatic cmp_all(input string pfx);
        int p0;
        chk({pfx, ".n_mac"}, q_f.size(), e_f.size());
        chk({pfx, ".n_wr"}, q_o.size(), e_o.size());
        for (int i = 0; i < q_f.size() && i < e_f.size(); i++) begin
            p0 = n_pass;
            chk($sformatf("%s.f[%0d]", pfx, i), q_f[i], e_f[i]);
            chk($sformatf("%s.w[%0d]", pfx, i), q_w[i], e_w[i]);
            chk($sformatf("%s.b[%0d]", pfx, i), q_b[i], e_b[i]);
            chk($sformatf("%s.clr[%0d]", pfx, i), q_clr[i], e_clr[i]);
            if (n_pass != p0 + 4) break;
        end
        for (int i = 0; i < q_o.size() && i < e_o.size(); i++) begin
            p0 = n_pass;
            chk($sformatf("%s.o[%0d]", pfx, i), q_o[i], e_o[i]);
            if (n_pass != p0 + 1) break;
        end
    endtask

    task automatic start_pulse(input int d);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input string pfx, input int budget);
        for (int i = 0; i < budget && c_fall < 0; i++) @(negedge clk);
        chk({pfx, ".finished"}, int'(c_fall >= 0), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        rst_v = '1; start_v = '0; stall_v = '0; sel = 1;
        mon_clear();
        repeat (3) @(negedge clk);
        chk("rst.busy", int'(db_busy), 0);
        chk("rst.done", int'(db_done), 0);
        chk("rst.mac_en", int'(db_en), 0);
        chk("rst.mac_clr", int'(db_clr), 0);
        chk("rst.o_wr_en", int'(db_wr), 0);
        chk("rst.f_raddr", int'(db_f), 0);
        chk("rst.w_raddr", int'(db_w), 0);
        chk("rst.o_waddr", int'(db_o), 0);
        rst_v = '0;
        @(negedge clk);

        // Config B, no stall
        build_exp(3, 6, 6, 1, 2, 2);
        mon_clear();
        start_pulse(1);
        chk("t2.busy_next", int'(db_busy), 1);
        wait_done("t2", 2000);
        cmp_all("t2");
        chk("t2.mac_lat", c_mac1 - c_busy1, 5);
        chk("t2.wr_lat", c_wr1 - c_busy1, 26);
        chk("t2.done_lat", c_done - c_busy1, 585);
        chk("t2.done_after_wr", c_done - c_wrl, 1);
        chk("t2.busy_fall", c_fall - c_done, 1);
        chk("t2.n_done", n_done, 1);
        chk("t2.w_oc1_first", q_w[288], 18);
        chk("t2.w_oc1_last", q_w[305], 35);
        chk("t2.b_oc1", q_b[288], 1);
        chk("t2.f_ic1", q_f[9], 36);
        chk("t2.clr_first", q_clr[0], 1);
        chk("t2.clr_second", q_clr[1], 0);

        // Config B, random stall in the first 400 cycles plus a stall on the last tap
        mon_clear();
        ns = 0;
        start_pulse(1);
        for (int k = 1; k <= 577 + ns; k++) begin
            bit r;
            r = (k <= 400) && ($urandom_range(0, 99) < 30);
            if (r) ns++;
            stall_v[1] = r || (k >= 576 + ns);
            @(negedge clk);
        end
        stall_v[1] = 1'b0;
        wait_done("t4", 2000);
        cmp_all("t4");
        chk("t4.n_mac", q_f.size(), 576);
        chk("t4.done_lat", c_done - c_busy1, 587 + ns);
        chk("t4.n_done", n_done, 1);

        // Config B, reset mid-run then a clean rerun
        mon_clear();
        start_pulse(1);
        repeat (99) @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        chk("t5.busy_after_rst", int'(db_busy), 0);
        mon_clear();
        repeat (30) @(negedge clk);
        chk("t5.no_wr", q_o.size(), 0);
        chk("t5.no_done", n_done, 0);
        mon_clear();
        start_pulse(1);
        wait_done("t5", 2000);
        cmp_all("t5");
        chk("t5.done_lat", c_done - c_busy1, 585);

        // Config B, start during RUN and FLUSH ignored; back-to-back start after done
        mon_clear();
        start_pulse(1);
        repeat (50) @(negedge clk);
        start_pulse(1);
        repeat (527) @(negedge clk);
        chk("t6.busy_in_flush", int'(db_busy), 1);
        start_pulse(1);
        for (int i = 0; i < 100 && c_done < 0; i++) @(negedge clk);
        chk("t6.wr_cnt", q_o.size(), 32);
        chk("t6.n_done", n_done, 1);
        chk("t6.done_lat", c_done - c_busy1, 585);
        @(negedge clk);
        chk("t6.idle_after_done", int'(db_busy), 0);
        mon_clear();
        start_pulse(1);
        chk("t6.busy_again", int'(db_busy), 1);
        wait_done("t6b", 2000);
        cmp_all("t6b");

        // Config C: stride 2
        sel = 2;
        build_exp(2, 8, 8, 2, 1, 1);
        @(negedge clk);
        mon_clear();
        start_pulse(2);
        wait_done("t3", 500);
        cmp_all("t3");
        chk("t3.n_wr", q_o.size(), 16);
        chk("t3.f20", q_f[20], 18);
        chk("t3.f21", q_f[21], 19);
        chk("t3.f22", q_f[22], 26);
        chk("t3.f23", q_f[23], 27);

        // Config A: defaults, single output channel
        sel = 0;
        build_exp(5, 32, 32, 1, 1, 1);
        @(negedge clk);
        mon_clear();
        start_pulse(0);
        wait_done("t1", 21000);
        cmp_all("t1");
        chk("t1.n_mac", q_f.size(), 19600);
        chk("t1.n_wr", q_o.size(), 784);
        chk("t1.f_first", q_f[0], 0);
        chk("t1.mac_lat", c_mac1 - c_busy1, 5);
        chk("t1.wr30_addr", q_o[29], 29);
        chk("t1.wr30_f_start", q_f[725], 33);
        chk("t1.done_after_wr", c_done - c_wrl, 1);
        chk("t1.busy_fall", c_fall - c_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
